// File: rtl/afe_ctrl.sv
// afe_ctrl: SPI-programmed analog-front-end controller (register file, GPIO, injection pulse train, hit latches/counters)
// Ports:
//   clk_i     system clock, at least 4x the SPI clock
//   rst_b_i   asynchronous active-low reset
//   sclk_i    SPI clock, mode 0
//   cs_b_i    SPI chip select, active low
//   mosi_i    SPI data in, MSB first; frame = {W/R, addr[6:0], data[7:0]}
//   miso_o    SPI data out, high-Z while deselected
//   inj_i     external injection strobe
//   comp_i    asynchronous comparator outputs, one per channel
//   hit_o     latched hit flags
//   inj_o     injection net = synced inj_i OR internal pulse
//   gpio_o    general-purpose register outputs
//   led_o     high while the pulse train runs
module afe_ctrl #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_b_i,
    input  logic            sclk_i,
    input  logic            cs_b_i,
    input  logic            mosi_i,
    output wire             miso_o,
    input  logic            inj_i,
    input  logic [N_CH-1:0] comp_i,
    output logic [N_CH-1:0] hit_o,
    output logic            inj_o,
    output logic [7:0]      gpio_o,
    output logic            led_o
);
    localparam int SW = N_CH + 4;
    // chip select resets to its idle (high) level so reset never looks like an open frame
    localparam logic [SW-1:0] SYNC_RST = SW'(2);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic [SW-1:0]    sync_q [SYNC_STAGES];
    logic             sclk_s, cs_s, mosi_s, inj_s;
    logic [N_CH-1:0]  comp_s;
    logic             sclk_q, cs_q, inj_q;
    logic [N_CH-1:0]  comp_q;
    logic             sclk_rise, sclk_fall, cs_rise;
    logic [4:0]       bit_q;
    logic [15:0]      shift_q;
    logic [7:0]       rd_q, rd_data;
    logic [6:0]       rd_addr, wr_addr;
    logic [7:0]       wr_data;
    logic             miso_q, wr, start, abort;
    logic [7:0]       gpio_q, wid_q, per_q, num_q;
    logic [N_CH-1:0]  ch_en_q;
    state_t           state_q, state_d;
    logic [7:0]       tmr_q, tmr_d, rem_q, rem_d, wid_m1_q, wid_m1_d, per_m1_q, per_m1_d;
    logic [6:0]       rem_sat;
    logic             inj_now, inj_fall;
    logic [N_CH-1:0]  hit_q, hit_set, cnt_clr;
    logic [CNT_W-1:0] cnt_q [N_CH];

    always_ff @(posedge clk_i or negedge rst_b_i)
        if (!rst_b_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= SYNC_RST;
        end else begin
            sync_q[0] <= {comp_i, inj_i, mosi_i, cs_b_i, sclk_i};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end

    assign {comp_s, inj_s, mosi_s, cs_s, sclk_s} = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_b_i)
        if (!rst_b_i) begin
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
            inj_q  <= 1'b0;
            comp_q <= '0;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
            inj_q  <= inj_now;
            comp_q <= comp_s;
        end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_s & ~cs_q;

    // Address of a read is complete once the 8th bit is sampled.
    assign rd_addr = {shift_q[5:0], mosi_s};
    assign rem_sat = rem_q > 8'd127 ? 7'd127 : rem_q[6:0];

    always_comb begin
        case (rd_addr)
            7'h00:   rd_data = gpio_q;
            7'h01:   rd_data = 8'(ch_en_q);
            7'h03:   rd_data = wid_q;
            7'h04:   rd_data = per_q;
            7'h05:   rd_data = num_q;
            7'h06:   rd_data = {rem_sat, state_q != IDLE};
            default: rd_data = 8'h00;
        endcase
        for (int i = 0; i < N_CH; i++)
            if (rd_addr == 7'(16 + i)) rd_data = 8'(cnt_q[i]);
    end

    // bit_q saturates so overlong frames never alias back to 16.
    always_ff @(posedge clk_i or negedge rst_b_i)
        if (!rst_b_i) begin
            bit_q   <= '0;
            shift_q <= '0;
            rd_q    <= '0;
            miso_q  <= 1'b0;
        end else if (cs_s) begin
            bit_q  <= '0;
            miso_q <= 1'b0;
        end else begin
            if (sclk_rise) begin
                shift_q <= {shift_q[14:0], mosi_s};
                bit_q   <= bit_q + 5'(bit_q != 5'd31);
                if (bit_q == 5'd7) rd_q <= rd_data;
            end
            if (sclk_fall) miso_q <= (bit_q[4:3] == 2'b01) & rd_q[~bit_q[2:0]];
        end

    assign miso_o = cs_s ? 1'bz : miso_q;

    // bit_q still holds the final count in the cycle the deselect edge is seen.
    assign wr      = cs_rise & (bit_q == 5'd16) & shift_q[15];
    assign wr_addr = shift_q[14:8];
    assign wr_data = shift_q[7:0];
    assign abort   = wr & (wr_addr == 7'h02) & wr_data[1];
    assign start   = wr & (wr_addr == 7'h02) & wr_data[0] & ~wr_data[1];

    always_ff @(posedge clk_i or negedge rst_b_i)
        if (!rst_b_i) begin
            gpio_q  <= '0;
            ch_en_q <= '0;
            wid_q   <= '0;
            per_q   <= '0;
            num_q   <= '0;
        end else if (wr) begin
            case (wr_addr)
                7'h00:   gpio_q  <= wr_data;
                7'h01:   ch_en_q <= wr_data[N_CH-1:0];
                7'h03:   wid_q   <= wr_data;
                7'h04:   per_q   <= wr_data;
                7'h05:   num_q   <= wr_data;
                default: ;
            endcase
        end

    // Timer holds (phase length - 1); widths/period are snapshotted at START.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        rem_d    = rem_q;
        wid_m1_d = wid_m1_q;
        per_m1_d = per_m1_q;
        if (abort) begin
            state_d = IDLE;
            tmr_d   = '0;
            rem_d   = '0;
        end else if (state_q == IDLE) begin
            if (start && num_q != 8'd0) begin
                state_d  = HIGH;
                wid_m1_d = wid_q - 8'(wid_q != 8'd0);
                per_m1_d = per_q - 8'(per_q != 8'd0);
                tmr_d    = wid_m1_d;
                rem_d    = num_q;
            end
        end else if (tmr_q != 8'd0) begin
            tmr_d = tmr_q - 8'd1;
        end else if (state_q == LOW) begin
            state_d = HIGH;
            tmr_d   = wid_m1_q;
        end else if (rem_q > 8'd1) begin
            state_d = LOW;
            tmr_d   = per_m1_q;
            rem_d   = rem_q - 8'd1;
        end else begin
            state_d = IDLE;
            rem_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_b_i)
        if (!rst_b_i) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            rem_q    <= '0;
            wid_m1_q <= '0;
            per_m1_q <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            rem_q    <= rem_d;
            wid_m1_q <= wid_m1_d;
            per_m1_q <= per_m1_d;
        end

    // A hit needs INJ high now, so it can never coincide with the INJ falling edge.
    assign inj_now  = inj_s | (state_q == HIGH);
    assign inj_fall = inj_q & ~inj_now;
    assign hit_set  = comp_s & ~comp_q & ch_en_q & {N_CH{inj_now}};

    always_comb begin
        cnt_clr = '0;
        for (int i = 0; i < N_CH; i++) cnt_clr[i] = wr & (wr_addr == 7'(16 + i));
    end

    always_ff @(posedge clk_i or negedge rst_b_i)
        if (!rst_b_i) begin
            hit_q <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            hit_q <= inj_fall ? '0 : hit_q | hit_set;
            for (int i = 0; i < N_CH; i++)
                cnt_q[i] <= cnt_clr[i] ? '0 : cnt_q[i] + CNT_W'(hit_set[i] & ~hit_q[i] & (cnt_q[i] != '1));
        end

    assign hit_o  = hit_q;
    assign inj_o  = inj_now;
    assign gpio_o = gpio_q;
    assign led_o  = state_q != IDLE;
endmodule

// File: tb/tb_afe_ctrl.sv
// tb_afe_ctrl: randomized scoreboard bench for afe_ctrl against a register/hit/pulse-train reference model
module tb_afe_ctrl;
    localparam int N_CH = 4;
    localparam int CNT_W = 2;
    localparam int CMAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [7:0] v;
        logic [7:0] m;
        logic [6:0] a;
    } exp_t;

    logic clk = 1'b0, rst_b = 1'b0, sclk = 1'b0, cs_b = 1'b1, mosi = 1'b0, inj_in = 1'b0;
    logic [N_CH-1:0] comp = '0;
    wire miso;
    logic [N_CH-1:0] hit;
    logic inj_out, led;
    logic [7:0] gpio;

    int total = 0, bad = 0;
    exp_t q[$];
    logic [7:0] m_gpio = 0, m_en = 0, m_wid = 0, m_per = 0, m_num = 0;
    int m_cnt[N_CH] = '{default: 0};
    logic [6:0] al[15] = '{7'h00, 7'h01, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h0f,
                           7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h17, 7'h7f};

    afe_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_b_i(rst_b), .sclk_i(sclk), .cs_b_i(cs_b), .mosi_i(mosi),
        .miso_o(miso), .inj_i(inj_in), .comp_i(comp), .hit_o(hit), .inj_o(inj_out),
        .gpio_o(gpio), .led_o(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mexp(input logic [6:0] a);
        case (a)
            7'h00: return m_gpio;
            7'h01: return m_en;
            7'h03: return m_wid;
            7'h04: return m_per;
            7'h05: return m_num;
            default: return (a >= 7'h10 && a < 7'(16 + N_CH)) ? 8'(m_cnt[a - 7'h10]) : 8'h00;
        endcase
    endfunction

    function automatic int sat(input int v);
        return v > CMAX ? CMAX : v;
    endfunction

    task automatic spi(input logic [15:0] f, input int nb, input int tail);
        cs_b = 1'b0;
        #40;
        for (int i = 0; i < nb; i++) begin
            mosi = f[15];
            f = f << 1;
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
        #40 cs_b = 1'b1;
        #(tail);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        spi({1'b1, a, d}, 16, 100);
    endtask

    task automatic mwr(input logic [6:0] a, input logic [7:0] d);
        case (a)
            7'h00: m_gpio = d;
            7'h01: m_en = d & 8'((1 << N_CH) - 1);
            7'h03: m_wid = d;
            7'h04: m_per = d;
            7'h05: m_num = d;
            default: if (a >= 7'h10 && a < 7'(16 + N_CH)) m_cnt[a - 7'h10] = 0;
        endcase
        wr(a, d);
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] v, input logic [7:0] m);
        q.push_back('{v: v, m: m, a: a});
        spi({1'b0, a, 8'h00}, 16, 100);
    endtask

    task automatic wait_inj(input logic lvl, input int lim, input string nm);
        int k = 0;
        while (inj_out !== lvl && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, inj_out, lvl);
    endtask

    // One external-strobe window: each enabled channel that sees any rising comparator edge counts once.
    task automatic hit_window(input logic [N_CH-1:0] f);
        logic [N_CH-1:0] any, m;
        any = '0;
        inj_in = 1'b1;
        #60;
        for (int k = 0; k < 2; k++) begin
            m = N_CH'($urandom) | f;
            any |= m;
            comp = m;
            #40 comp = '0;
            #40;
        end
        @(negedge clk);
        chk("hit_set", hit, any & m_en[N_CH-1:0]);
        for (int i = 0; i < N_CH; i++) if (any[i] && m_en[i]) m_cnt[i] = sat(m_cnt[i] + 1);
        inj_in = 1'b0;
        #60 @(negedge clk);
        chk("hit_clr", hit, '0);
    endtask

    task automatic train(input logic [7:0] w, input logic [7:0] p, input logic [7:0] n);
        int hi[$], lo[$];
        int ledc, run, we, pe, nn;
        logic prev;
        ledc = 0; run = 0; prev = 1'b0; nn = int'(n);
        we = (w == 0) ? 1 : int'(w);
        pe = (p == 0) ? 1 : int'(p);
        mwr(7'h03, w);
        mwr(7'h04, p);
        mwr(7'h05, n);
        spi({1'b1, 7'h02, 8'h01}, 16, 0);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (inj_out !== prev) begin
                if (prev) hi.push_back(run);
                else if (hi.size() > 0) lo.push_back(run);
                run = 0;
                prev = inj_out;
            end
            run++;
            ledc += int'(led);
        end
        chk("pulse_count", hi.size(), nn);
        foreach (hi[k]) chk("pulse_high", hi[k], we);
        foreach (lo[k]) chk("pulse_low", lo[k], pe);
        chk("led_cycles", ledc, nn == 0 ? 0 : nn * we + (nn - 1) * pe);
    endtask

    initial begin : monitor
        logic [15:0] mo, mi;
        int n;
        exp_t e;
        mo = '0; mi = '0; n = 0;
        forever begin
            @(posedge sclk or posedge cs_b);
            if (cs_b) begin
                if (n == 16 && !mo[15]) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rd_unexpected: got %h expected none", mi);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("rd_%02h", e.a), {mi[15:8], mi[7:0] & e.m}, {8'h00, e.v & e.m});
                    end
                end
                n = 0;
            end else begin
                mo = {mo[14:0], mosi};
                mi = {mi[14:0], miso};
                n++;
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a;
        #20;
        chk("rst_gpio", gpio, 8'h00);
        chk("rst_hit", hit, '0);
        chk("rst_inj", inj_out, 1'b0);
        chk("rst_led", led, 1'b0);
        #20 rst_b = 1'b1;
        repeat (3) @(negedge clk);
        foreach (al[k]) rd(al[k], mexp(al[k]), 8'hff);

        mwr(7'h00, 8'hA5);
        @(negedge clk);
        chk("gpio_a5", gpio, 8'hA5);
        rd(7'h00, 8'hA5, 8'hff);
        spi({1'b1, 7'h00, 8'hFF}, 10, 100);
        chk("gpio_short10", gpio, 8'hA5);
        spi({1'b1, 7'h00, 8'hFF}, 15, 100);
        chk("gpio_short15", gpio, 8'hA5);
        spi({1'b1, 7'h00, 8'hFF}, 17, 100);
        chk("gpio_long17", gpio, 8'hA5);
        rd(7'h00, 8'hA5, 8'hff);

        repeat (20) begin
            a = al[$urandom_range(0, 14)];
            mwr(a, 8'($urandom));
            @(negedge clk);
            chk("gpio_rand", gpio, m_gpio);
            a = al[$urandom_range(0, 14)];
            rd(a, mexp(a), 8'hff);
        end

        repeat (6) begin
            mwr(7'h01, 8'($urandom));
            hit_window('0);
            if ($urandom_range(0, 2) == 0) mwr(7'(16 + $urandom_range(0, N_CH - 1)), 8'($urandom));
            for (int i = 0; i < N_CH; i++) rd(7'(16 + i), mexp(7'(16 + i)), 8'hff);
        end

        mwr(7'h01, 8'h01);
        repeat (5) hit_window(4'b0001);
        rd(7'h10, 8'(CMAX), 8'hff);
        mwr(7'h10, 8'h55);
        rd(7'h10, 8'h00, 8'hff);

        train(8'd3, 8'd5, 8'd2);
        train(8'd0, 8'd0, 8'd1);
        train(8'd2, 8'd2, 8'd0);
        repeat (3) train(8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)), 8'($urandom_range(1, 4)));
        rd(7'h06, 8'h00, 8'hff);

        mwr(7'h03, 8'd200);
        mwr(7'h05, 8'd1);
        wr(7'h02, 8'h01);
        wait_inj(1'b1, 300, "int_inj_rise");
        comp = 4'b0011;
        #40 comp = '0;
        #40 @(negedge clk);
        chk("hit_internal", hit, 4'b0001);
        m_cnt[0] = sat(m_cnt[0] + 1);
        wait_inj(1'b0, 300, "int_inj_fall");
        #40 @(negedge clk);
        chk("hit_internal_clr", hit, '0);
        rd(7'h10, mexp(7'h10), 8'hff);
        rd(7'h11, mexp(7'h11), 8'hff);

        mwr(7'h03, 8'd200);
        mwr(7'h04, 8'd200);
        mwr(7'h05, 8'd10);
        wr(7'h02, 8'h01);
        wait_inj(1'b1, 300, "abort_p1_rise");
        wait_inj(1'b0, 300, "abort_p1_fall");
        wait_inj(1'b1, 300, "abort_p2_rise");
        rd(7'h06, 8'h01, 8'h01);
        wait_inj(1'b0, 300, "abort_p2_fall");
        wr(7'h02, 8'h03);
        @(negedge clk);
        chk("abort_inj", inj_out, 1'b0);
        chk("abort_led", led, 1'b0);
        rd(7'h06, 8'h00, 8'hff);
        wr(7'h02, 8'h03);
        chk("abort_wins_led", led, 1'b0);

        wr(7'h02, 8'h01);
        wait_inj(1'b1, 300, "rst_train_rise");
        #20 rst_b = 1'b0;
        #1;
        chk("rst_mid_inj", inj_out, 1'b0);
        chk("rst_mid_led", led, 1'b0);
        chk("rst_mid_gpio", gpio, 8'h00);
        #19 rst_b = 1'b1;
        m_gpio = 0; m_en = 0; m_wid = 0; m_per = 0; m_num = 0;
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        repeat (3) @(negedge clk);
        rd(7'h06, 8'h00, 8'hff);
        rd(7'h05, mexp(7'h05), 8'hff);
        rd(7'h10, mexp(7'h10), 8'hff);
        chk("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
